// File: rtl/skid_fifo_pkg.sv
// skid_fifo_pkg: shared helpers for the skid_fifo elastic buffer
package skid_fifo_pkg;

    function automatic int fill_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/skid_fifo_mem.sv
// skid_fifo_mem: DEPTH x DW register array, one write port, one async read port
//   clk                  write clock
//   we, waddr, wdata     write port
//   raddr -> rdata       combinational read port
module skid_fifo_mem #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];

endmodule

// File: rtl/skid_fifo.sv
// skid_fifo: registered-output valid/ready elastic buffer holding up to DEPTH beats
//   i_clk, i_reset           clock, synchronous active-high reset
//   i_flush                  synchronous discard (only with SKID_FIFO_FLUSH_EN defined)
//   i_valid, o_ready, i_data upstream beat
//   o_valid, i_ready, o_data downstream beat
//   o_fill, o_almost_full    occupancy and o_fill >= AFULL_THRESH
// o_ready/o_valid decode from fill only, so neither depends combinationally on any input.
module skid_fifo
    import skid_fifo_pkg::*;
#(
    parameter int DW           = 8,
    parameter int DEPTH        = 4,
    parameter int AFULL_THRESH = DEPTH - 1
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
`ifdef SKID_FIFO_FLUSH_EN
    input  logic                         i_flush,
`endif
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [DW-1:0]                i_data,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [DW-1:0]                o_data,
    output logic [fill_width(DEPTH)-1:0] o_fill,
    output logic                         o_almost_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = fill_width(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0)
        $error("skid_fifo: DEPTH must be a power of two >= 2");
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH)
        $error("skid_fifo: AFULL_THRESH must be in 1..DEPTH");

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [FW-1:0] fill;
    logic          push, pop, clr;

`ifdef SKID_FIFO_FLUSH_EN
    assign clr = i_reset || i_flush;
`else
    assign clr = i_reset;
`endif

    assign o_ready       = fill != FW'(DEPTH);
    assign o_valid       = fill != '0;
    assign o_fill        = fill;
    assign o_almost_full = fill >= FW'(AFULL_THRESH);
    assign push          = i_valid && o_ready;
    assign pop           = o_valid && i_ready;

    always_ff @(posedge i_clk)
        if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fill <= fill + FW'(push) - FW'(pop);
        end

    // A write in a clear cycle lands in a slot that the reset pointers treat as empty.
    skid_fifo_mem #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk   (i_clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (i_data),
        .raddr (rd_ptr),
        .rdata (o_data)
    );

endmodule

// File: tb/tb_skid_fifo.sv
// tb_skid_fifo: directed table plus corner-case sequences for skid_fifo (DEPTH=4, AFULL_THRESH=3)
module tb_skid_fifo;

    logic       clk = 0, rst = 1, valid = 0, ready = 0, flush = 0;
    logic [7:0] din = 0, dout;
    logic       ovalid, oready, af;
    logic [2:0] fill;
    int         total = 0, bad = 0;

    always #5 clk = ~clk;

    skid_fifo #(.DW(8), .DEPTH(4), .AFULL_THRESH(3)) dut (
        .i_clk         (clk),
        .i_reset       (rst),
`ifdef SKID_FIFO_FLUSH_EN
        .i_flush       (flush),
`endif
        .i_valid       (valid),
        .o_ready       (oready),
        .i_data        (din),
        .o_valid       (ovalid),
        .i_ready       (ready),
        .o_data        (dout),
        .o_fill        (fill),
        .o_almost_full (af)
    );

    typedef struct {
        logic       rst, v;
        logic [7:0] d;
        logic       r;
        logic       ov, ordy;
        logic [7:0] od;
        logic [2:0] fl;
        logic       af;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic ov, input logic ordy, input logic [7:0] od,
                             input logic [2:0] fl, input logic a);
        chk({tag, "_valid"}, ovalid, ov);
        chk({tag, "_ready"}, oready, ordy);
        chk({tag, "_fill"}, fill, fl);
        chk({tag, "_afull"}, af, a);
        if (ov) chk({tag, "_data"}, dout, od);
    endtask

    initial begin
        // rst v  d     r   ov ordy od    fill af
        tbl.push_back('{1, 1, 8'hAA, 1, 0, 1, 8'h00, 0, 0});
        tbl.push_back('{1, 1, 8'hAB, 1, 0, 1, 8'h00, 0, 0});
        tbl.push_back('{0, 1, 8'h11, 0, 0, 1, 8'h00, 0, 0});
        tbl.push_back('{0, 1, 8'h22, 0, 1, 1, 8'h11, 1, 0});
        tbl.push_back('{0, 1, 8'h33, 0, 1, 1, 8'h11, 2, 0});
        tbl.push_back('{0, 1, 8'h44, 0, 1, 1, 8'h11, 3, 1});
        tbl.push_back('{0, 1, 8'h55, 0, 1, 0, 8'h11, 4, 1});
        tbl.push_back('{0, 0, 8'h00, 1, 1, 0, 8'h11, 4, 1});
        tbl.push_back('{0, 0, 8'h00, 1, 1, 1, 8'h22, 3, 1});
        tbl.push_back('{0, 0, 8'h00, 1, 1, 1, 8'h33, 2, 0});
        tbl.push_back('{0, 0, 8'h00, 1, 1, 1, 8'h44, 1, 0});
        tbl.push_back('{0, 1, 8'h01, 0, 0, 1, 8'h00, 0, 0});
        tbl.push_back('{0, 1, 8'h02, 0, 1, 1, 8'h01, 1, 0});
        tbl.push_back('{0, 1, 8'h03, 0, 1, 1, 8'h01, 2, 0});
        tbl.push_back('{0, 1, 8'h04, 0, 1, 1, 8'h01, 3, 1});
        tbl.push_back('{0, 1, 8'h99, 1, 1, 0, 8'h01, 4, 1});
        tbl.push_back('{0, 1, 8'h99, 1, 1, 1, 8'h02, 3, 1});
        tbl.push_back('{0, 0, 8'h00, 1, 1, 1, 8'h03, 3, 1});
        tbl.push_back('{0, 0, 8'h00, 1, 1, 1, 8'h04, 2, 0});
        tbl.push_back('{0, 0, 8'h00, 1, 1, 1, 8'h99, 1, 0});
        tbl.push_back('{0, 0, 8'h00, 0, 0, 1, 8'h00, 0, 0});

        rst = 1; valid = 1; din = 8'hA9;
        step();
        foreach (tbl[i]) begin
            rst = tbl[i].rst; valid = tbl[i].v; din = tbl[i].d; ready = tbl[i].r;
            chk_state($sformatf("vec%0d", i), tbl[i].ov, tbl[i].ordy, tbl[i].od, tbl[i].fl, tbl[i].af);
            step();
        end

        // Stall: head beat must hold while the upstream data bus toggles.
        valid = 1; din = 8'h5A; ready = 0;
        step();
        valid = 0;
        for (int k = 0; k < 5; k++) begin
            din = (k % 2) ? 8'hFF : 8'h00;
            chk_state("stall", 1, 1, 8'h5A, 1, 0);
            step();
        end
        ready = 1;
        step();
        ready = 0;
        chk_state("stall_drained", 0, 1, 8'h00, 0, 0);

        // Random streaming with wrap: beats 0..19 must come out in order.
        begin
            int sent = 0, got = 0, cyc = 0, mfill = 0;
            logic p, q;
            while (got < 20 && cyc < 2000) begin
                valid = (sent < 20) && ($urandom_range(1) == 1);
                din = sent[7:0];
                ready = $urandom_range(1) == 1;
                chk("stream_fill", fill, mfill);
                chk("stream_fill_max", fill <= 3'd4, 1);
                p = valid && oready;
                q = ovalid && ready;
                if (q) begin
                    chk("stream_data", dout, got);
                    got++;
                end
                if (p) sent++;
                mfill = mfill + int'(p) - int'(q);
                step();
                cyc++;
            end
            chk("stream_count", got, 20);
            valid = 0; ready = 0;
            chk_state("stream_end", 0, 1, 8'h00, 0, 0);
        end

`ifdef SKID_FIFO_FLUSH_EN
        // Flush at fill 3 with a simultaneous push: everything, 0x77 included, is discarded.
        valid = 1;
        for (int k = 0; k < 3; k++) begin
            din = 8'h60 + 8'(k);
            step();
        end
        chk_state("pre_flush", 1, 1, 8'h60, 3, 1);
        flush = 1; din = 8'h77; ready = 1;
        step();
        flush = 0; valid = 0;
        chk_state("post_flush", 0, 1, 8'h00, 0, 0);
        for (int k = 0; k < 3; k++) begin
            chk("flush_no_beat", ovalid, 0);
            step();
        end
        ready = 0;
`endif

        // Reset mid-burst discards stored beats.
        valid = 1; din = 8'hC3;
        step();
        step();
        rst = 1;
        step();
        rst = 0; valid = 0;
        chk_state("mid_reset", 0, 1, 8'h00, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/skid_fifo.md
# skid_fifo

Parametrised, registered-output valid/ready elastic buffer, the multi-entry successor to the two-register skid buffer. It decouples an upstream producer from a downstream consumer by up to DEPTH beats. Backpressure (o_ready) is derived from internal state only, so there is no combinational path from i_ready to o_ready. It sits on any streaming datapath where timing closure or burst absorption needs more than one skid slot.

## Interface
- DW, 8, data width in bits (>=1)
- DEPTH, 4, number of storage entries; power of two, >=2
- AFULL_THRESH, DEPTH-1, o_almost_full asserts when fill >= this value (1..DEPTH)
- i_clk  input  1  clock; all state updates on rising edge
- i_reset  input  1  synchronous, active-high reset
- i_valid  input  1  upstream beat valid
- o_ready  output  1  buffer can accept a beat this cycle
- i_data  input  DW  upstream beat data
- o_valid  output  1  downstream beat valid
- i_ready  input  1  downstream accepts beat this cycle
- o_data  output  DW  downstream beat data
- o_fill  output  $clog2(DEPTH)+1  current number of stored beats
- o_almost_full  output  1  o_fill >= AFULL_THRESH
- i_flush  input  1  synchronous discard of all contents (present only with SKID_FIFO_FLUSH_EN)

## Operation
- Reset is synchronous on i_clk, active-high, via i_reset; it clears state on the rising edge where it is sampled high.
- push = i_valid && o_ready; pop = o_valid && i_ready.
- Storage: circular buffer, write pointer wr_ptr and read pointer rd_ptr, each $clog2(DEPTH) bits; they wrap naturally modulo DEPTH.
- fill: push&&!pop -> +1; pop&&!push -> -1; both or neither -> unchanged.
- o_ready = (fill != DEPTH); o_valid = (fill != 0); o_data = mem[rd_ptr]. All are decoded from registers only.
- o_almost_full = (fill >= AFULL_THRESH).
- While o_valid && !i_ready, o_data and o_valid stay stable (AXI-stream rule).
- Full with pop: no push that cycle because o_ready is 0. fill drops to DEPTH-1 and o_ready rises the next cycle.
- Empty: no pop is possible. A push makes the beat visible the next cycle.
- Full with simultaneous push and pop is impossible, since o_ready=0. At every other fill level, simultaneous push and pop keeps fill constant and both pointers advance.
- Data storage is not reset. Contents are don't-care while o_valid=0.
- Reset values:
  - wr_ptr = rd_ptr = 0, fill = 0
  - o_valid = 0, o_ready = 1, o_fill = 0
  - o_almost_full = 0
  - o_data is undefined
- Reset mid-burst discards all stored beats. Beats presented upstream in the reset cycle are dropped.

## Timing
- Latency: a beat pushed in cycle N appears on o_valid/o_data in cycle N+1 (empty buffer, no bypass).
- Throughput: one beat per cycle sustained, with both sides valid/ready at any fill 1..DEPTH-1.
- o_ready deasserts the cycle after the DEPTH-th beat is accepted without a pop.
- o_ready never depends combinationally on i_valid, i_ready or i_data.
- o_valid never depends combinationally on i_valid, i_ready or i_data.

## Configuration
- SKID_FIFO_FLUSH_EN defined:
  - i_flush port exists.
  - i_flush=1 at an edge sets pointers and fill to 0, exactly as reset does.
  - Push and pop in the flush cycle are ignored, including the data transfer.
  - i_reset has priority over i_flush.
  - o_valid=0 and o_ready=1 the following cycle.
- Not defined:
  - No i_flush port.
  - Contents are cleared only by i_reset.

## Structure
- Package skid_fifo_pkg holds a function fill_width(DEPTH) returning $clog2(DEPTH)+1.
- Parameter legality checks (DEPTH power of two, AFULL_THRESH in range) are elaboration-time assertions in the top module.
- One sub-module, skid_fifo_mem, holds the DEPTH x DW register array:
  - one write port (we, waddr, wdata)
  - one asynchronous read port (raddr -> rdata)
- Pointer/fill control lives in skid_fifo.

## Test plan
- Reset: hold i_reset 3 cycles with i_valid=1 -> o_valid=0, o_ready=1, o_fill=0, o_almost_full=0 throughout and the cycle after release; no beat is emitted.
- Fill then drain, DEPTH=4:
  - Push 0x11,0x22,0x33,0x44 with i_ready=0 -> o_fill 1,2,3,4; o_almost_full high at fill 3; o_ready=0 after the 4th beat.
  - Then i_ready=1 -> outputs 0x11,0x22,0x33,0x44 in order, one per cycle; o_valid=0 afterwards.
- Stall stability: with o_valid=1 and o_data=0x5A, hold i_ready=0 for 5 cycles while upstream toggles i_data -> o_data remains 0x5A.
- Full plus pop:
  - At fill=4, i_valid=1 with i_data=0x99 and i_ready=1 -> 0x99 is not accepted that cycle, fill=3.
  - Next cycle 0x99 is accepted, fill stays 3 if the pop continues.
- Streaming and wrap: 20 sequential beats 0..19 with random i_valid/i_ready (~50%) -> the output sequence is exactly 0..19 and o_fill never exceeds 4.
- Flush (SKID_FIFO_FLUSH_EN): at fill=3, pulse i_flush together with push 0x77 -> next cycle fill=0, o_valid=0, and 0x77 never appears on the output.
